updown_counter_param: RTL

Parametrised synchronous up/down counter with enable, parallel load, programmable modulus and selectable wrap/saturate mode. It supersedes the fixed 4-bit up/down counter as the general counting primitive for timers, address generators and event counters. It reports terminal-count status combinationally and registered wrap/saturation events for downstream sequencing logic.

---
 rtl/updown_counter_param.sv | 98 +++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised synchronous up/down counter with
// enable, parallel load, programmable modulus (0..mod_max) and selectable
// wrap/saturate behaviour at the bounds. q, wrap and sat_hit are registered.
// at_term is decoded combinationally from q, dir and mod_max.
module updown_counter_param #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] q,
  output logic             at_term,
  output logic             wrap,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             sat_hit_r;

  logic [WIDTH-1:0] q_next_s;
  logic             wrap_next_s;
  logic             sat_hit_next_s;

  // Next-state decode: load beats count; bounds are checked before any
  // increment/decrement so q+1 and q-1 can never leave 0..2^WIDTH-1.
  always_comb begin
    q_next_s       = q_r;
    wrap_next_s    = 1'b0;
    sat_hit_next_s = 1'b0;
    if (load) begin
      if (load_val > mod_max) begin
        q_next_s = mod_max;
      end else begin
        q_next_s = load_val;
      end
    end else if (en) begin
      if (dir == 1'b0) begin
        if (q_r < mod_max) begin
          q_next_s = q_r + ONE_C;
        end else if (sat == 1'b0) begin
          q_next_s    = ZERO_C;
          wrap_next_s = 1'b1;
        end else begin
          q_next_s       = mod_max;
          sat_hit_next_s = 1'b1;
        end
      end else begin
        if (q_r > mod_max) begin
          // Out of range (e.g. after reset or a shrinking modulus): re-enter
          // at the top of the range without flagging an event.
          q_next_s = mod_max;
        end else if (q_r != ZERO_C) begin
          q_next_s = q_r - ONE_C;
        end else if (sat == 1'b0) begin
          q_next_s    = mod_max;
          wrap_next_s = 1'b1;
        end else begin
          q_next_s       = ZERO_C;
          sat_hit_next_s = 1'b1;
        end
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r       <= RST_VAL;
      wrap_r    <= 1'b0;
      sat_hit_r <= 1'b0;
    end else begin
      q_r       <= q_next_s;
      wrap_r    <= wrap_next_s;
      sat_hit_r <= sat_hit_next_s;
    end
  end

  assign q       = q_r;
  assign wrap    = wrap_r;
  assign sat_hit = sat_hit_r;

  // Terminal count for the current direction; deliberately independent of en.
  assign at_term = ((dir == 1'b0) && (q_r >= mod_max)) ||
                   ((dir == 1'b1) && (q_r == ZERO_C));

endmodule
